// File: rtl/pipe_stage_reg_pkg.sv
// ============================================================================
// Module  : pipe_stage_reg_pkg
// Purpose : Shared settings for the pipeline stage register. This file holds
//           the default word width and the bubble instruction, plus the types
//           and helpers used by pipe_stage_reg and skid_buffer_2e.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

`ifndef NOP_INSTR
`define NOP_INSTR 32'h0000_0013
`endif

`default_nettype none

package pipe_stage_reg_pkg;

  // Occupancy state of the two-slot elastic buffer
  localparam int unsigned PSR_STATE_W = 2;
  typedef logic [PSR_STATE_W-1:0] psr_state_t;

  // Width of one beat when pc and instruction travel side by side
  function automatic int unsigned psr_beat_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_skid_buffer_2e.sv
// ============================================================================
// Module  : skid_buffer_2e
// Purpose : Generic two-entry elastic buffer with a registered ready output
//           and a synchronous flush. The main slot drives the output; the
//           skid slot catches the single beat that arrives in the cycle
//           where backpressure has not yet reached the registered ready.
// Ports   : clk, rst        clock / synchronous active-high reset
//           flush_i         empty both slots at the next edge (data held)
//           in_valid_i      upstream offers in_data_i
//           in_ready_o      registered; 1 unless both slots are occupied
//           in_data_i       incoming beat (W bits)
//           out_valid_o     main slot holds a live entry
//           out_ready_i     downstream consumes this cycle
//           out_data_o      main slot contents (W bits)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module skid_buffer_2e
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  // Occupancy encoding: EMPTY (no entries), FULL (main only), BUSY (main+skid)
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;

  psr_state_t   state_q,     state_d;
  logic         in_ready_q,  in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] main_q,      main_d;
  logic [W-1:0] skid_q,      skid_d;

  logic accept;
  logic consume;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Flush beats any transfer; slot data is left in place so the
      // downstream pc field does not glitch.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data_i;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_d = in_data_i;
          end else if (accept) begin
            skid_d  = in_data_i;
            state_d = ST_BUSY;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          // in_ready is low here, so only the drain of main can happen;
          // the skid entry moves up behind it to keep arrival order.
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Both handshake outputs are decoded from the next state so that they
    // leave the block straight from flops.
    in_ready_d  = (state_d != ST_BUSY);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module  : pipe_stage_reg
// Purpose : Elastic pipeline stage register carrying pc and instruction
//           between CPU stages. Valid/ready handshake with a registered
//           in_ready, one-entry skid, synchronous flush inserting a NOP
//           bubble, and a saturating stall counter.
// Ports   : clk, rst          clock / synchronous active-high reset
//           flush             kill stage contents at the next edge
//           in_valid/in_ready upstream handshake (in_ready registered)
//           pc_in             incoming pc            (WIDTH)
//           instruction_in    incoming instruction   (WIDTH)
//           out_valid/out_ready downstream handshake
//           pc                registered pc          (WIDTH)
//           instruction       registered instruction, NOP_INSTR when idle
//           stall_cnt         saturating count of stalled output cycles
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned         WIDTH     = `WORD_WIDTH,
  parameter logic [WIDTH-1:0]    NOP_INSTR = `NOP_INSTR,
  parameter int unsigned         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic [WIDTH-1:0]     instruction_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     instruction,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam int unsigned BEAT_W = psr_beat_width(WIDTH);

  logic [BEAT_W-1:0]    beat_in;
  logic [BEAT_W-1:0]    beat_out;
  logic                 buf_valid;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // pc occupies the upper half of the beat, instruction the lower half
  assign beat_in = {pc_in, instruction_in};

  skid_buffer_2e #(
    .W (BEAT_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (beat_in),
    .out_valid_o (buf_valid),
    .out_ready_i (out_ready),
    .out_data_o  (beat_out)
  );

  assign out_valid = buf_valid;
  assign pc        = beat_out[BEAT_W-1:WIDTH];

  // Bubble substitution: both inputs to this mux are flops, so no input
  // reaches the instruction output combinationally.
  assign instruction = buf_valid ? beat_out[WIDTH-1:0] : NOP_INSTR;

  // Stall counter: one count per cycle the output is held, sticking at
  // all-ones; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (buf_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module  : tb_pipe_stage_reg
// Purpose : Self-checking bench for pipe_stage_reg. A queue-based model of
//           the stage (up to two held beats, in-order) predicts every output
//           after each rising edge. Two instances share the stimulus: the
//           default one and one with a 3-bit stall counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  pc_in, instruction_in;

  logic          in_ready, out_valid;
  logic [W-1:0]  pc, instruction;
  logic [15:0]   stall_cnt;

  logic          in_ready3, out_valid3;
  logic [W-1:0]  pc3, instruction3;
  logic [2:0]    stall_cnt3;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instruction(instruction), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid3), .out_ready(out_ready),
    .pc(pc3), .instruction(instruction3), .stall_cnt(stall_cnt3)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } beat_t;

  beat_t       q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          stall_m     = 0;
  int          stall3_m    = 0;
  logic [31:0] pc_m        = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the stage is a FIFO of at most two beats. Space is judged on
  // occupancy at the start of the cycle; flush empties it, reset clears all.
  task automatic model_edge();
    bit acc, con;
    if (rst) begin
      q.delete();
      pc_m     = '0;
      stall_m  = 0;
      stall3_m = 0;
    end else begin
      acc = in_valid && (q.size() < 2);
      con = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready) begin
        if (stall_m < 65535) stall_m++;
        if (stall3_m < 7) stall3_m++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back('{pc: pc_in, ins: instruction_in});
      end
      if (q.size() > 0) pc_m = q[0].pc;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_ins;
    exp_ins = (q.size() > 0) ? q[0].ins : NOP;
    chk("in_ready",    {63'd0, in_ready},   {63'd0, (q.size() < 2)});
    chk("out_valid",   {63'd0, out_valid},  {63'd0, (q.size() > 0)});
    chk("instruction", {32'd0, instruction}, {32'd0, exp_ins});
    chk("pc",          {32'd0, pc},         {32'd0, pc_m});
    chk("stall_cnt",   {48'd0, stall_cnt},  64'(stall_m));
    chk("stall_cnt3",  {61'd0, stall_cnt3}, 64'(stall3_m));
    chk("out_valid3",  {63'd0, out_valid3}, {63'd0, (q.size() > 0)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit ordy, input bit fl);
    in_valid       = v;
    pc_in          = p;
    instruction_in = p ^ 32'hA5A5_0000;
    out_ready      = ordy;
    flush          = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset for two cycles
    cycle();
    cycle();
    chk("rst_instr",     {32'd0, instruction}, {32'd0, NOP});
    chk("rst_pc",        {32'd0, pc},          64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},    64'd1);
    chk("rst_out_valid", {63'd0, out_valid},   64'd0);
    chk("rst_stall",     {48'd0, stall_cnt},   64'd0);
    rst = 1'b0;

    // Streaming at full rate
    drive(1'b1, 32'h100, 1'b1, 1'b0); cycle();
    chk("stream_v0",  {63'd0, out_valid}, 64'd1);
    chk("stream_pc0", {32'd0, pc}, 64'h100);
    drive(1'b1, 32'h104, 1'b1, 1'b0); cycle();
    chk("stream_pc1", {32'd0, pc}, 64'h104);
    drive(1'b1, 32'h108, 1'b1, 1'b0); cycle();
    chk("stream_pc2", {32'd0, pc}, 64'h108);
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
    chk("stream_idle_instr", {32'd0, instruction}, {32'd0, NOP});

    // Backpressure into BUSY, third beat held off, then drain in order
    drive(1'b1, 32'h200, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h204, 1'b0, 1'b0); cycle();
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h208, 1'b0, 1'b0); cycle();
    chk("busy_hold_pc", {32'd0, pc}, 64'h200);
    drive(1'b1, 32'h208, 1'b1, 1'b0); cycle();
    chk("drain_pc1", {32'd0, pc}, 64'h204);
    drive(1'b1, 32'h208, 1'b1, 1'b0); cycle();
    chk("drain_pc2", {32'd0, pc}, 64'h208);
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Stall counter: clear, load one beat, hold it
    rst = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b0); cycle();
    rst = 1'b0;
    drive(1'b1, 32'h500, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("stall5",  {48'd0, stall_cnt},  64'd5);
    for (int i = 0; i < 5; i++) cycle();
    chk("stall10",     {48'd0, stall_cnt},  64'd10);
    chk("stall3_sat",  {61'd0, stall_cnt3}, 64'd7);

    // Flush while BUSY with a beat offered in the same cycle
    drive(1'b1, 32'h2F0, 1'b0, 1'b0); cycle();
    chk("pre_flush_busy", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h300, 1'b0, 1'b1); cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_pc_hold", {32'd0, pc}, 64'h500);
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
    cycle();

    // Reset and flush together while FULL
    drive(1'b1, 32'h400, 1'b0, 1'b0); cycle();
    rst = 1'b1; drive(1'b1, 32'h404, 1'b0, 1'b1); cycle();
    chk("rf_pc",    {32'd0, pc}, 64'd0);
    chk("rf_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("rf_stall", {48'd0, stall_cnt}, 64'd0);
    rst = 1'b0;

    // Random handshake against the model
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
